// File: rtl/inst_byte_streamer.sv
// -----------------------------------------------------------------------------
// inst_byte_streamer
//
// Feeds the byte-serial fetch/decode stage with instruction bytes. Words are
// read from instruction memory with a fixed load latency, held in a small
// word FIFO, and handed out one byte per cycle on inst/pc. The decoder can
// hold the stream with stall and restart it at a new byte address with flush.
//
// Ports:
//   clk        - sole clock
//   rstn       - asynchronous active-low reset (acts as a flush to RESET_PC)
//   mem_req    - a word read is issued this cycle
//   mem_addr   - word-aligned byte address of the read
//   mem_rdata  - read data, valid LOAD_LATENCY cycles after the request
//   inst       - current instruction byte (8'h00 when byte_valid=0)
//   pc         - byte address of inst
//   byte_valid - inst/pc are meaningful
//   stall      - consumer holds the current byte
//   flush      - discard everything and restart at flush_pc
//   flush_pc   - redirect byte address, sampled when flush=1
// -----------------------------------------------------------------------------
module inst_byte_streamer #(
    parameter int          LOAD_LATENCY = 1,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  inst,
    output logic [31:0] pc,
    output logic        byte_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam int          CW          = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] RESET_FETCH = {RESET_PC[31:2], 2'b00};

    // Number of reads still travelling through the memory pipeline.
    function automatic logic [31:0] popcount(input logic [LOAD_LATENCY-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < LOAD_LATENCY; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    logic                    run_q, run_d;
    logic [31:0]             fetch_addr_q, fetch_addr_d;
    logic [31:0]             pc_q, pc_d;
    logic [1:0]              off_q, off_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [LOAD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [31:0]             fifo_q [FIFO_DEPTH];

    logic        consume;
    logic        push;
    logic        pop;
    logic [31:0] occupancy;
    logic [31:0] head_word;

    // run_q holds requests off until the first edge after reset release, so
    // mem_req stays low throughout reset even though the FIFO is empty.
    assign occupancy  = 32'(count_q) + popcount(vld_pipe_q);
    assign mem_req    = run_q && (occupancy < 32'(FIFO_DEPTH));
    assign mem_addr   = fetch_addr_q;
    assign byte_valid = (count_q != '0);
    assign pc         = pc_q;
    assign head_word  = fifo_q[rd_ptr_q];
    assign inst       = byte_valid ? head_word[{off_q, 3'b000} +: 8] : 8'h00;

    assign consume = byte_valid && !stall && !flush;
    assign pop     = consume && (off_q == 2'd3);
    // Data landing on a flush edge belongs to the old stream and is dropped.
    assign push    = vld_pipe_q[LOAD_LATENCY-1] && !flush;

    always_comb begin
        run_d        = 1'b1;
        fetch_addr_d = fetch_addr_q;
        pc_d         = pc_q;
        off_d        = off_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        vld_pipe_d   = vld_pipe_q;

        if (flush) begin
            // The request issued in this cycle is not shifted in, so its
            // data is ignored when memory returns it.
            fetch_addr_d = {flush_pc[31:2], 2'b00};
            pc_d         = flush_pc;
            off_d        = flush_pc[1:0];
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            vld_pipe_d   = '0;
        end else begin
            if (mem_req) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
            end
            vld_pipe_d[0] = mem_req;
            for (int i = 1; i < LOAD_LATENCY; i++) begin
                vld_pipe_d[i] = vld_pipe_q[i-1];
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (consume) begin
                pc_d  = pc_q + 32'd1;
                off_d = off_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // ---- control registers ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q        <= 1'b0;
            fetch_addr_q <= RESET_FETCH;
            pc_q         <= RESET_PC;
            off_q        <= RESET_PC[1:0];
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            vld_pipe_q   <= '0;
        end else begin
            run_q        <= run_d;
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
            off_q        <= off_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            vld_pipe_q   <= vld_pipe_d;
        end
    end

    // ---- word storage (data only, never reset) ----
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_inst_byte_streamer.sv
// -----------------------------------------------------------------------------
// tb_inst_byte_streamer
//
// Two streamers (LOAD_LATENCY 1 and 3) share clock, reset, stall and flush.
// Each has its own latency-accurate memory and a byte-level reference: the
// byte at address a is the XOR of a's four bytes, pc advances by one per
// consumed byte, and the stream is valid from LOAD_LATENCY+1 edges after a
// restart onwards.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_byte_streamer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] fb(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
    endfunction

    function automatic logic [31:0] mw(input logic [31:0] a);
        return {fb(a + 32'd3), fb(a + 32'd2), fb(a + 32'd1), fb(a)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int          LL  = (g == 0) ? 1 : 3;
        localparam logic [31:0] RPC = (g == 0) ? 32'h0 : 32'h0000_1003;

        logic        mem_req;
        logic [31:0] mem_addr;
        logic [31:0] mem_rdata;
        logic [7:0]  inst;
        logic [31:0] pc;
        logic        byte_valid;

        logic        req_s;
        logic [31:0] addr_s;
        logic [31:0] a_pipe [LL];
        logic        v_pipe [LL];
        logic [31:0] junk;

        int          since     = -1;
        logic [31:0] epc       = RPC;
        int          stall_run = 0;
        string       p         = (g == 0) ? "ll1_" : "ll3_";

        inst_byte_streamer #(
            .LOAD_LATENCY(LL),
            .FIFO_DEPTH  (4),
            .RESET_PC    (RPC)
        ) u_dut (
            .clk       (clk),
            .rstn      (rstn),
            .mem_req   (mem_req),
            .mem_addr  (mem_addr),
            .mem_rdata (mem_rdata),
            .inst      (inst),
            .pc        (pc),
            .byte_valid(byte_valid),
            .stall     (stall),
            .flush     (flush),
            .flush_pc  (flush_pc)
        );

        // Memory: a request seen in cycle k returns its word in cycle k+LL;
        // otherwise the bus carries random junk.
        assign mem_rdata = v_pipe[LL-1] ? mw(a_pipe[LL-1]) : junk;

        always @(posedge clk) begin
            junk <= $urandom;
            if (!rstn) begin
                for (int i = 0; i < LL; i++) v_pipe[i] <= 1'b0;
            end else begin
                v_pipe[0] <= req_s;
                a_pipe[0] <= addr_s;
                for (int i = 1; i < LL; i++) begin
                    v_pipe[i] <= v_pipe[i-1];
                    a_pipe[i] <= a_pipe[i-1];
                end
            end
        end

        always @(negedge clk) begin
            logic ebv;
            req_s  <= mem_req;
            addr_s <= mem_addr;
            if (!rstn) begin
                since     = -1;
                epc       = RPC;
                stall_run = 0;
                chk({p, "rst_bv"},   32'(byte_valid), 32'd0);
                chk({p, "rst_req"},  32'(mem_req),    32'd0);
                chk({p, "rst_pc"},   pc,              RPC);
                chk({p, "rst_inst"}, 32'(inst),       32'd0);
                chk({p, "rst_addr"}, mem_addr,        {RPC[31:2], 2'b00});
            end else begin
                ebv = (since >= LL + 1);
                chk({p, "bv"}, 32'(byte_valid), 32'(ebv));
                if (ebv) begin
                    chk({p, "pc"},   pc,       epc);
                    chk({p, "inst"}, 32'(inst), 32'(fb(epc)));
                end else begin
                    chk({p, "inst_idle"}, 32'(inst), 32'd0);
                end
                if (since == -1) chk({p, "req_pre"}, 32'(mem_req), 32'd0);
                if (since == 0) begin
                    chk({p, "req_first"},  32'(mem_req), 32'd1);
                    chk({p, "addr_first"}, mem_addr,     {epc[31:2], 2'b00});
                end
                if (stall_run >= 10) chk({p, "req_full"}, 32'(mem_req), 32'd0);
                chk({p, "addr_align"}, 32'(mem_addr[1:0]), 32'd0);
                chk({p, "no_ovf"},
                    (32'(u_dut.count_q) > 32'd4 || u_dut.occupancy > 32'd4) ? 32'd1 : 32'd0,
                    32'd0);

                if (flush) begin
                    since     = 0;
                    epc       = flush_pc;
                    stall_run = 0;
                end else begin
                    if (ebv && !stall) epc = epc + 32'd1;
                    if (since < 100000) since = since + 1;
                    stall_run = stall ? stall_run + 1 : 0;
                end
            end
        end
    end

    task automatic step(input logic s, input logic f, input logic [31:0] fp);
        @(posedge clk);
        #2;
        stall    = s;
        flush    = f;
        flush_pc = fp;
    endtask

    initial begin
        logic        s;
        logic        f;
        logic [31:0] fp;
        rstn     = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        flush_pc = '0;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;

        // Sequential stream from reset, then a long stall and its release.
        repeat (20) step(1'b0, 1'b0, 32'h0);
        repeat (12) step(1'b1, 1'b0, 32'h0);
        repeat (8)  step(1'b0, 1'b0, 32'h0);

        // Redirect mid-word, redirect combined with stall, pc wrap.
        step(1'b0, 1'b1, 32'h0000_0102);
        repeat (15) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0040);
        repeat (15) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hFFFF_FFFD);
        repeat (20) step(1'b0, 1'b0, 32'h0);

        // Random stall/flush traffic, including back-to-back flushes.
        for (int i = 0; i < 800; i++) begin
            s  = ($urandom_range(3) == 0);
            f  = ($urandom_range(40) == 0);
            fp = ($urandom_range(1) == 0) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(15)));
            step(s, f, fp);
        end
        repeat (10) step(1'b0, 1'b0, 32'h0);

        // Asynchronous reset between edges takes effect immediately.
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("ll1_async_bv",  32'(g_inst[0].byte_valid), 32'd0);
        chk("ll1_async_pc",  g_inst[0].pc,              32'h0);
        chk("ll1_async_req", 32'(g_inst[0].mem_req),    32'd0);
        chk("ll3_async_bv",  32'(g_inst[1].byte_valid), 32'd0);
        chk("ll3_async_pc",  g_inst[1].pc,              32'h0000_1003);
        chk("ll3_async_req", 32'(g_inst[1].mem_req),    32'd0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        repeat (30) step(1'b0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
